// File: rtl/missile_collision_if.sv
// Pixel-stream inputs and collision report outputs of missile_collision.
// master drives the scan/drawing requests; slave is the collision block.
interface missile_collision_if #(
    parameter int COORD_WIDTH = 11,
    parameter int COUNT_WIDTH = 16
);
    logic                   startOfFrame;
    logic [COORD_WIDTH-1:0] pixelX;
    logic [COORD_WIDTH-1:0] pixelY;
    logic                   missileDR;
    logic                   alienDR;
    logic                   borderDR;
    logic                   missileHit;
    logic                   missileOut;
    logic [COORD_WIDTH-1:0] hitX;
    logic [COORD_WIDTH-1:0] hitY;
    logic                   explodeActive;
    logic [COUNT_WIDTH-1:0] hitCount;

    modport master (
        output startOfFrame, pixelX, pixelY, missileDR, alienDR, borderDR,
        input  missileHit, missileOut, hitX, hitY, explodeActive, hitCount
    );

    modport slave (
        input  startOfFrame, pixelX, pixelY, missileDR, alienDR, borderDR,
        output missileHit, missileOut, hitX, hitY, explodeActive, hitCount
    );
endinterface

// File: rtl/missile_collision.sv
// Latches the first missile/alien overlap of each frame and reports one hit or
// exit pulse at the next frame boundary, with a post-hit cooldown and hit counter.
module missile_collision #(
    parameter int COORD_WIDTH     = 11,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    missile_collision_if.slave   bus
);
    localparam int CNT_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    localparam logic [CNT_W-1:0] CD_LOAD = CNT_W'(COOLDOWN_FRAMES);

    typedef enum logic {SCAN, COOLDOWN} state_t;

    state_t                 state, state_next;
    logic [CNT_W-1:0]       cd_cnt, cd_next;
    logic                   armed;
    logic                   hit_seen;
    logic                   exit_seen;
    logic [COORD_WIDTH-1:0] shadow_x, shadow_y;
    logic                   report_hit, report_exit;
    logic                   missile_hit, missile_out;
    logic [COORD_WIDTH-1:0] hit_x, hit_y;
    logic [COUNT_WIDTH-1:0] hit_count;
    logic                   coll, exit_ev;

    assign coll    = bus.missileDR & bus.alienDR;
    assign exit_ev = bus.missileDR & bus.borderDR;

    // Frame-boundary decisions; the pixel inputs of the boundary cycle are blanking.
    always_comb begin
        state_next  = state;
        cd_next     = cd_cnt;
        report_hit  = 1'b0;
        report_exit = 1'b0;
        if (bus.startOfFrame) begin
            case (state)
                SCAN: begin
                    if (armed) begin
                        if (hit_seen) begin
                            report_hit = 1'b1;
                            if (COOLDOWN_FRAMES > 0) begin
                                state_next = COOLDOWN;
                                cd_next    = CD_LOAD;
                            end
                        end else if (exit_seen) begin
                            report_exit = 1'b1;
                        end
                    end
                end
                COOLDOWN: begin
                    cd_next = cd_cnt - CNT_W'(1);
                    if (cd_cnt <= CNT_W'(1)) begin
                        state_next = SCAN;
                        cd_next    = '0;
                    end
                end
                default: state_next = SCAN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= SCAN;
            cd_cnt      <= '0;
            armed       <= 1'b0;
            hit_seen    <= 1'b0;
            exit_seen   <= 1'b0;
            shadow_x    <= '0;
            shadow_y    <= '0;
            missile_hit <= 1'b0;
            missile_out <= 1'b0;
            hit_x       <= '0;
            hit_y       <= '0;
            hit_count   <= '0;
        end else begin
            state       <= state_next;
            cd_cnt      <= cd_next;
            missile_hit <= report_hit;
            missile_out <= report_exit;
            if (bus.startOfFrame) begin
                hit_seen  <= 1'b0;
                exit_seen <= 1'b0;
                armed     <= 1'b1;
            end else begin
                if (coll && !hit_seen) begin
                    hit_seen <= 1'b1;
                    shadow_x <= bus.pixelX;
                    shadow_y <= bus.pixelY;
                end
                if (exit_ev) begin
                    exit_seen <= 1'b1;
                end
            end
            if (report_hit) begin
                hit_x <= shadow_x;
                hit_y <= shadow_y;
                if (hit_count != '1) begin
                    hit_count <= hit_count + COUNT_WIDTH'(1);
                end
            end
        end
    end

    assign bus.missileHit    = missile_hit;
    assign bus.missileOut    = missile_out;
    assign bus.hitX          = hit_x;
    assign bus.hitY          = hit_y;
    assign bus.hitCount      = hit_count;
    assign bus.explodeActive = (state == COOLDOWN);
endmodule
